// File: rtl/scan_test_sequencer.sv
// Scan test sequencer: fetches test vectors, shifts them into a scan chain, pulses one capture
// cycle, and compares primary outputs and unloaded state against expectations.
module scan_test_sequencer #(
  parameter int unsigned FF        = 25,
  parameter int unsigned IN_WIDTH  = 3,
  parameter int unsigned OUT_WIDTH = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [IN_WIDTH-1:0]  vec_pi,
  input  logic [FF-1:0]        vec_scan,
  input  logic [FF-1:0]        vec_exp_st,
  input  logic [OUT_WIDTH-1:0] vec_exp_po,
  input  logic                 vec_last,
  output logic [IN_WIDTH-1:0]  pi,
  output logic                 si,
  output logic                 nbar_t,
  input  logic                 so,
  input  logic [OUT_WIDTH-1:0] po,
  output logic                 busy,
  output logic                 done,
  output logic                 detected,
  output logic [15:0]          vec_count,
  output logic [15:0]          fail_index
);

  localparam int unsigned CntW = $clog2(FF + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(FF - 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StShift,
    StCapture,
    StCompare,
    StFlush,
    StFinish
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [FF-1:0]          shift_q, shift_d;
  logic [FF-1:0]          cap_q, cap_d;
  logic [FF-1:0]          exp_st_q, exp_st_d;
  logic [FF-1:0]          prev_st_q, prev_st_d;
  logic [IN_WIDTH-1:0]    pi_q, pi_d;
  logic [OUT_WIDTH-1:0]   exp_po_q, exp_po_d;
  logic [OUT_WIDTH-1:0]   po_q, po_d;
  logic                   last_q, last_d;
  logic                   seen_q, seen_d;
  logic                   det_q, det_d;
  logic [15:0]            count_q, count_d;
  logic [15:0]            fail_q, fail_d;

  logic [FF-1:0]          cap_shift;
  logic                   restart;

  assign cap_shift = {cap_q[FF-2:0], so};
  assign restart   = start && (state_q == StIdle || state_q == StFinish);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    cap_d     = cap_q;
    exp_st_d  = exp_st_q;
    prev_st_d = prev_st_q;
    pi_d      = pi_q;
    exp_po_d  = exp_po_q;
    po_d      = po_q;
    last_d    = last_q;
    seen_d    = seen_q;
    det_d     = det_q;
    count_d   = count_q;
    fail_d    = fail_q;
    vec_ready = 1'b0;
    busy      = 1'b1;
    nbar_t    = 1'b1;
    si        = 1'b0;

    case (state_q)
      StIdle: busy = 1'b0;
      StFetch: begin
        vec_ready = 1'b1;
        if (vec_valid) begin
          shift_d   = vec_scan;
          pi_d      = vec_pi;
          exp_po_d  = vec_exp_po;
          last_d    = vec_last;
          // The unload of this vector carries the response of the previous one.
          prev_st_d = exp_st_q;
          exp_st_d  = vec_exp_st;
          count_d   = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
          state_d   = StShift;
        end
      end
      StShift: begin
        si      = shift_q[FF-1];
        shift_d = {shift_q[FF-2:0], 1'b0};
        cap_d   = cap_shift;
        if (cnt_q == CntLast) state_d = StCapture;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      StCapture: begin
        nbar_t  = 1'b0;
        po_d    = po;
        state_d = StCompare;
      end
      StCompare: begin
        seen_d = 1'b1;
        if ((po_q != exp_po_q) || (seen_q && (cap_q != prev_st_q))) begin
          det_d   = 1'b1;
          fail_d  = count_q - 16'd1;
          state_d = StFinish;
        end else if (last_q) begin
          state_d = StFlush;
        end else begin
          state_d = StFetch;
        end
      end
      StFlush: begin
        cap_d = cap_shift;
        if (cnt_q == CntLast) begin
          // Final bit arrives this cycle, so compare against the shifted value.
          if (cap_shift != exp_st_q) begin
            det_d  = 1'b1;
            fail_d = count_q - 16'd1;
          end
          state_d = StFinish;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StFinish: busy = 1'b0;
      default: state_d = StIdle;
    endcase

    if (restart) begin
      det_d   = 1'b0;
      count_d = '0;
      fail_d  = '0;
      seen_d  = 1'b0;
      state_d = StFetch;
    end

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      cap_q     <= '0;
      exp_st_q  <= '0;
      prev_st_q <= '0;
      pi_q      <= '0;
      exp_po_q  <= '0;
      po_q      <= '0;
      last_q    <= 1'b0;
      seen_q    <= 1'b0;
      det_q     <= 1'b0;
      count_q   <= '0;
      fail_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      cap_q     <= cap_d;
      exp_st_q  <= exp_st_d;
      prev_st_q <= prev_st_d;
      pi_q      <= pi_d;
      exp_po_q  <= exp_po_d;
      po_q      <= po_d;
      last_q    <= last_d;
      seen_q    <= seen_d;
      det_q     <= det_d;
      count_q   <= count_d;
      fail_q    <= fail_d;
    end
  end

  assign pi         = pi_q;
  assign done       = (state_q == StFinish);
  assign detected   = det_q;
  assign vec_count  = count_q;
  assign fail_index = fail_q;

endmodule

// File: tb/tb_scan_test_sequencer.sv
// Bench for scan_test_sequencer: a gated scan-chain model with identity capture, a vector
// driver that pushes per-vector expectations, and a monitor that pops them at each capture.
module tb_scan_test_sequencer;

  localparam int unsigned FF = 25;
  localparam int unsigned IW = 3;
  localparam int unsigned OW = 6;

  logic          clk = 1'b0;
  logic          rst, start, vec_valid, vec_ready, vec_last;
  logic [IW-1:0] vec_pi, pi;
  logic [FF-1:0] vec_scan, vec_exp_st;
  logic [OW-1:0] vec_exp_po, po;
  logic          si, nbar_t, so, busy, done, detected;
  logic [15:0]   vec_count, fail_index;

  always #5 clk = ~clk;

  scan_test_sequencer #(.FF(FF), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .vec_valid  (vec_valid),
    .vec_ready  (vec_ready),
    .vec_pi     (vec_pi),
    .vec_scan   (vec_scan),
    .vec_exp_st (vec_exp_st),
    .vec_exp_po (vec_exp_po),
    .vec_last   (vec_last),
    .pi         (pi),
    .si         (si),
    .nbar_t     (nbar_t),
    .so         (so),
    .po         (po),
    .busy       (busy),
    .done       (done),
    .detected   (detected),
    .vec_count  (vec_count),
    .fail_index (fail_index)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] po_fn(input logic [FF-1:0] st, input logic [IW-1:0] p);
    return {st[FF-1 -: IW] ^ p, st[OW-IW-1:0]};
  endfunction

  // Circuit under test: only clocked while the monitor says the sequencer is driving it.
  logic [FF-1:0] chain = 25'h0ABCDE1;
  logic          scan_en = 1'b0;
  assign so = chain[FF-1];
  assign po = po_fn(chain, pi);
  always @(posedge clk) if (scan_en && nbar_t) chain <= {chain[FF-2:0], si};

  typedef struct {
    logic [IW-1:0] pi;
    logic [FF-1:0] scan;
    logic          flush;
  } item_t;
  item_t sb_q[$];
  int    hs_issued = 0;

  // Monitor
  int            hs_seen = 0;
  int            phase   = 0;
  int            sh      = 0;
  logic [FF-1:0] rec     = '0;
  always begin
    item_t it;
    @(posedge clk);
    #1;
    if (hs_issued != hs_seen) begin
      hs_seen = hs_issued;
      phase   = 1;
      sh      = 0;
    end
    scan_en = 1'b0;
    if (rst) begin
      phase = 0;
    end else begin
      case (phase)
        1: begin
          scan_en = 1'b1;
          if (nbar_t) begin
            if (sh < FF) rec[FF-1-sh] = si;
            sh++;
            if (sh > FF + 4) begin
              check_eq("capture_timeout", sh, FF);
              phase = 0;
            end
          end else if (sb_q.size() == 0) begin
            check_eq("sb_size", sb_q.size(), 1);
            phase = 0;
          end else begin
            it = sb_q.pop_front();
            check_eq("cap_pi", pi, it.pi);
            check_eq("shift_cycles", sh, FF);
            check_eq("si_order", rec, it.scan);
            phase = it.flush ? 2 : 0;
          end
        end
        2: begin
          phase = 3;
          sh    = 0;
        end
        3: begin
          scan_en = 1'b1;
          sh++;
          if (sh == FF) phase = 0;
        end
        default: ;
      endcase
    end
  end

  logic [FF-1:0] t_scan[4];
  logic [FF-1:0] t_exp_st[4];
  logic [IW-1:0] t_pi[4];
  logic [OW-1:0] t_exp_po[4];

  task automatic fill(input int n);
    for (int k = 0; k < n; k++) begin
      t_scan[k]   = FF'($urandom);
      t_pi[k]     = IW'($urandom);
      t_exp_st[k] = t_scan[k];
      t_exp_po[k] = po_fn(t_scan[k], t_pi[k]);
    end
  endtask

  task automatic drive_vec(input int k, input int n);
    vec_valid  = 1'b1;
    vec_pi     = t_pi[k];
    vec_scan   = t_scan[k];
    vec_exp_st = t_exp_st[k];
    vec_exp_po = t_exp_po[k];
    vec_last   = (k == n - 1);
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, ".vec_ready"}, vec_ready, 0);
    check_eq({tag, ".si"}, si, 0);
    check_eq({tag, ".nbar_t"}, nbar_t, 1);
    check_eq({tag, ".pi"}, pi, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".detected"}, detected, 0);
    check_eq({tag, ".vec_count"}, vec_count, 0);
    check_eq({tag, ".fail_index"}, fail_index, 0);
  endtask

  task automatic run_session(input int n, input string tag);
    logic exp_det = 1'b0, cmp_det = 1'b0;
    int   exp_fi = 0, exp_cnt = n, acc = 0, ready_hi = 0;
    item_t it;
    for (int k = 0; k < n; k++) begin
      if (!cmp_det && ((t_exp_po[k] != po_fn(t_scan[k], t_pi[k])) ||
                       (k > 0 && t_exp_st[k-1] != t_scan[k-1]))) begin
        cmp_det = 1'b1;
        exp_fi  = k;
        exp_cnt = k + 1;
      end
    end
    exp_det = cmp_det;
    if (!cmp_det && t_exp_st[n-1] != t_scan[n-1]) begin
      exp_det = 1'b1;
      exp_fi  = n - 1;
    end

    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < n; k++) begin
      drive_vec(k, n);
      for (int w = 0; w < 200 && !vec_ready && !done; w++) @(negedge clk);
      if (!vec_ready) begin
        vec_valid = 1'b0;
        break;
      end
      it.pi    = t_pi[k];
      it.scan  = t_scan[k];
      it.flush = (k == n - 1) && !cmp_det;
      sb_q.push_back(it);
      hs_issued++;
      acc++;
      @(negedge clk) vec_valid = 1'b0;
    end

    for (int w = 0; w < 300 && !done; w++) @(negedge clk);
    check_eq({tag, ".done"}, done, 1);
    check_eq({tag, ".detected"}, detected, exp_det);
    check_eq({tag, ".fail_index"}, fail_index, exp_fi);
    check_eq({tag, ".vec_count"}, vec_count, exp_cnt);
    check_eq({tag, ".accepted"}, acc, exp_cnt);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".sb_left"}, sb_q.size(), 0);
    for (int w = 0; w < 5; w++) begin
      if (vec_ready || !nbar_t) ready_hi++;
      @(negedge clk);
    end
    check_eq({tag, ".finish_quiet"}, ready_hi, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; vec_valid = 1'b0; vec_last = 1'b0;
    vec_pi = '0; vec_scan = '0; vec_exp_st = '0; vec_exp_po = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk) rst = 1'b0;

    fill(3);
    run_session(3, "s1_match");

    fill(3);
    t_exp_po[1] = t_exp_po[1] ^ 6'h04;
    run_session(3, "s2_po_miss");

    fill(3);
    t_exp_st[2] = t_exp_st[2] ^ 25'h0000100;
    run_session(3, "s3_flush_miss");

    fill(2);
    run_session(2, "s4_first_skip");

    fill(1);
    t_scan[0]   = 25'h1000001;
    t_exp_st[0] = t_scan[0];
    t_exp_po[0] = po_fn(t_scan[0], t_pi[0]);
    run_session(1, "s5_si_order");

    // Reset mid-shift, with a start pulse while busy beforehand.
    fill(1);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    drive_vec(0, 1);
    for (int w = 0; w < 20 && !vec_ready; w++) @(negedge clk);
    check_eq("s6.ready", vec_ready, 1);
    sb_q.push_back('{pi: t_pi[0], scan: t_scan[0], flush: 1'b1});
    hs_issued++;
    @(negedge clk) vec_valid = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("s6.busy", busy, 1);
    check_eq("s6.vec_count", vec_count, 1);
    check_eq("s6.vec_ready", vec_ready, 0);
    check_eq("s6.nbar_t", nbar_t, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset("s6_rst");
    @(negedge clk) rst = 1'b0;
    sb_q.delete();

    fill(1);
    run_session(1, "s7_after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
